// File: rtl/mem_arbiter.sv
// mem_arbiter: serialises instruction and data requests onto a single RAM port.
// Data accesses win over instruction fetches; a watchdog aborts accesses that
// never see ACCESS and raises a sticky memerr. All outputs are registered.
module mem_arbiter #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              imemREN,
  input  logic [ADDR_W-1:0] imemaddr,
  output logic [DATA_W-1:0] imemload,
  output logic              ihit,
  input  logic              dmemREN,
  input  logic              dmemWEN,
  input  logic [ADDR_W-1:0] dmemaddr,
  input  logic [DATA_W-1:0] dmemstore,
  output logic [DATA_W-1:0] dmemload,
  output logic              dhit,
  output logic              ramREN,
  output logic              ramWEN,
  output logic [ADDR_W-1:0] ramaddr,
  output logic [DATA_W-1:0] ramstore,
  input  logic [DATA_W-1:0] ramload,
  input  logic [1:0]        ramstate,
  output logic              memerr
);

  localparam int unsigned WdW = ($clog2(TIMEOUT + 1) > 1) ? $clog2(TIMEOUT + 1) : 1;

  localparam logic [1:0] RamAccess = 2'd2;
  localparam logic [1:0] RamError  = 2'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DACC = 2'd1,
    IACC = 2'd2,
    HIT  = 2'd3
  } stateType;

  stateType          state;
  stateType          stateNext;
  logic [WdW-1:0]    wd;
  logic [WdW-1:0]    wdNext;
  logic              isWrite;
  logic              isWriteNext;
  logic [ADDR_W-1:0] addrNext;
  logic [DATA_W-1:0] storeNext;
  logic [DATA_W-1:0] imemloadNext;
  logic [DATA_W-1:0] dmemloadNext;
  logic              ihitNext;
  logic              dhitNext;
  logic              memerrNext;
  logic              ramRENNext;
  logic              ramWENNext;
  logic              reqLive;

  // State register
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // Next-state, latched request and registered-output next values
  always_comb begin
    stateNext    = state;
    wdNext       = wd;
    isWriteNext  = isWrite;
    addrNext     = ramaddr;
    storeNext    = ramstore;
    imemloadNext = imemload;
    dmemloadNext = dmemload;
    ihitNext     = 1'b0;
    dhitNext     = 1'b0;
    memerrNext   = memerr;
    reqLive      = 1'b0;

    unique case (state)
      IDLE: begin
        if (dmemWEN || dmemREN) begin
          stateNext   = DACC;
          addrNext    = dmemaddr;
          storeNext   = dmemstore;
          isWriteNext = dmemWEN;
          wdNext      = '0;
        end else if (imemREN) begin
          stateNext   = IACC;
          addrNext    = imemaddr;
          isWriteNext = 1'b0;
          wdNext      = '0;
        end
      end
      DACC, IACC: begin
        reqLive = (state == DACC) ? (dmemREN || dmemWEN) : imemREN;
        wdNext  = wd + WdW'(1);
        if (ramstate == RamAccess) begin
          stateNext = HIT;
          if (state == DACC) begin
            dhitNext = 1'b1;
            if (!isWrite) begin
              dmemloadNext = ramload;
            end
          end else begin
            ihitNext     = 1'b1;
            imemloadNext = ramload;
          end
        end else if (ramstate == RamError) begin
          stateNext  = IDLE;
          memerrNext = 1'b1;
        end else if (wd == WdW'(TIMEOUT)) begin
          stateNext  = IDLE;
          memerrNext = 1'b1;
        end else if (!reqLive) begin
          stateNext = IDLE;
        end
      end
      HIT: begin
        stateNext = IDLE;
      end
      default: begin
        stateNext = IDLE;
      end
    endcase

    ramRENNext = ((stateNext == DACC) && !isWriteNext) || (stateNext == IACC);
    ramWENNext = (stateNext == DACC) && isWriteNext;
  end

  // Output and datapath registers
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      wd       <= '0;
      isWrite  <= 1'b0;
      ramaddr  <= '0;
      ramstore <= '0;
      imemload <= '0;
      dmemload <= '0;
      ihit     <= 1'b0;
      dhit     <= 1'b0;
      memerr   <= 1'b0;
      ramREN   <= 1'b0;
      ramWEN   <= 1'b0;
    end else begin
      wd       <= wdNext;
      isWrite  <= isWriteNext;
      ramaddr  <= addrNext;
      ramstore <= storeNext;
      imemload <= imemloadNext;
      dmemload <= dmemloadNext;
      ihit     <= ihitNext;
      dhit     <= dhitNext;
      memerr   <= memerrNext;
      ramREN   <= ramRENNext;
      ramWEN   <= ramWENNext;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenarios followed by randomized transactions
// checked against a word-array memory model with latency arithmetic.
module tb_mem_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned TO = 15;

  localparam logic [1:0] RsFree   = 2'd0;
  localparam logic [1:0] RsBusy   = 2'd1;
  localparam logic [1:0] RsAccess = 2'd2;
  localparam logic [1:0] RsError  = 2'd3;

  logic          CLK;
  logic          nRST;
  logic          imemREN;
  logic [AW-1:0] imemaddr;
  logic [DW-1:0] imemload;
  logic          ihit;
  logic          dmemREN;
  logic          dmemWEN;
  logic [AW-1:0] dmemaddr;
  logic [DW-1:0] dmemstore;
  logic [DW-1:0] dmemload;
  logic          dhit;
  logic          ramREN;
  logic          ramWEN;
  logic [AW-1:0] ramaddr;
  logic [DW-1:0] ramstore;
  logic [DW-1:0] ramload;
  logic [1:0]    ramstate;
  logic          memerr;

  int total = 0;
  int bad   = 0;

  logic [31:0] mem [16];

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .CLK(CLK), .nRST(nRST),
    .imemREN(imemREN), .imemaddr(imemaddr), .imemload(imemload), .ihit(ihit),
    .dmemREN(dmemREN), .dmemWEN(dmemWEN), .dmemaddr(dmemaddr),
    .dmemstore(dmemstore), .dmemload(dmemload), .dhit(dhit),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate), .memerr(memerr)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #300000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "simulation time limit");
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic checkAllZero(input string tag);
    check({tag, "_imemload"}, imemload, 32'h0);
    check({tag, "_dmemload"}, dmemload, 32'h0);
    check({tag, "_ihit"}, 32'(ihit), 32'h0);
    check({tag, "_dhit"}, 32'(dhit), 32'h0);
    check({tag, "_ramREN"}, 32'(ramREN), 32'h0);
    check({tag, "_ramWEN"}, 32'(ramWEN), 32'h0);
    check({tag, "_ramaddr"}, ramaddr, 32'h0);
    check({tag, "_ramstore"}, ramstore, 32'h0);
    check({tag, "_memerr"}, 32'(memerr), 32'h0);
  endtask

  initial begin
    int          kind;
    int          busy;
    int          idx;
    int          waitCnt;
    logic        isWr;
    logic        isI;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] expD;

    for (int i = 0; i < 16; i++) begin
      mem[i] = (32'(i) * 32'h9E3779B1) ^ 32'h13579BDF;
    end

    // Reset held two cycles with a pending fetch
    nRST = 1'b0; imemREN = 1'b1; imemaddr = 32'h40;
    dmemREN = 1'b0; dmemWEN = 1'b0; dmemaddr = '0; dmemstore = '0;
    ramload = '0; ramstate = RsFree;
    step();
    step();
    checkAllZero("reset");

    // Instruction fetch with two BUSY cycles
    nRST = 1'b1; ramstate = RsBusy;
    step();
    check("fetch_ren_c0", 32'(ramREN), 32'h1);
    check("fetch_addr", ramaddr, 32'h40);
    step();
    check("fetch_ren_c1", 32'(ramREN), 32'h1);
    check("fetch_nohit_c1", 32'(ihit), 32'h0);
    step();
    check("fetch_ren_c2", 32'(ramREN), 32'h1);
    ramstate = RsAccess; ramload = 32'h8C010004;
    step();
    check("fetch_ihit", 32'(ihit), 32'h1);
    check("fetch_imemload", imemload, 32'h8C010004);
    check("fetch_ren_off", 32'(ramREN), 32'h0);
    imemREN = 1'b0; ramstate = RsFree;
    step();
    check("fetch_ihit_pulse", 32'(ihit), 32'h0);

    // Data write and instruction fetch requested together
    imemREN = 1'b1; imemaddr = 32'h200;
    dmemWEN = 1'b1; dmemaddr = 32'h100; dmemstore = 32'hDEADBEEF;
    ramstate = RsAccess; ramload = 32'h24020007;
    step();
    check("prio_wen", 32'(ramWEN), 32'h1);
    check("prio_ren", 32'(ramREN), 32'h0);
    check("prio_addr", ramaddr, 32'h100);
    check("prio_store", ramstore, 32'hDEADBEEF);
    step();
    check("prio_dhit", 32'(dhit), 32'h1);
    check("prio_no_ihit", 32'(ihit), 32'h0);
    check("prio_dmemload_kept", dmemload, 32'h0);
    dmemWEN = 1'b0;
    waitCnt = 0;
    step();
    waitCnt++;
    while (!ihit && waitCnt < 10) begin
      check("prio_no_dhit", 32'(dhit), 32'h0);
      step();
      waitCnt++;
    end
    check("prio_ihit_gap", 32'(waitCnt), 32'd3);
    check("prio_imemload", imemload, 32'h24020007);
    imemREN = 1'b0; ramstate = RsFree;
    step();

    // RAM error during a data read
    dmemREN = 1'b1; dmemaddr = 32'h10; ramstate = RsBusy;
    step();
    check("err_ren", 32'(ramREN), 32'h1);
    ramstate = RsError;
    step();
    check("err_ren_off", 32'(ramREN), 32'h0);
    check("err_no_dhit", 32'(dhit), 32'h0);
    check("err_memerr", 32'(memerr), 32'h1);
    dmemREN = 1'b0; ramstate = RsFree;
    step();
    step();
    check("err_sticky", 32'(memerr), 32'h1);
    check("err_no_dhit_later", 32'(dhit), 32'h0);

    // Watchdog timeout with RAM held BUSY
    nRST = 1'b0;
    step();
    nRST = 1'b1;
    check("to_memerr_cleared", 32'(memerr), 32'h0);
    imemREN = 1'b1; imemaddr = 32'h80; ramstate = RsBusy;
    step();
    waitCnt = 0;
    while (ramREN && waitCnt < 40) begin
      waitCnt++;
      step();
    end
    imemREN = 1'b0;
    check("to_enable_cycles", 32'(waitCnt), 32'(TO + 1));
    check("to_memerr", 32'(memerr), 32'h1);
    check("to_no_ihit", 32'(ihit), 32'h0);
    ramstate = RsFree;
    nRST = 1'b0;
    step();
    nRST = 1'b1;

    // Requester withdraws a data read
    dmemREN = 1'b1; dmemaddr = 32'h20; ramstate = RsBusy;
    step();
    check("wd_ren_c0", 32'(ramREN), 32'h1);
    step();
    check("wd_ren_c1", 32'(ramREN), 32'h1);
    dmemREN = 1'b0;
    step();
    check("wd_ren_off", 32'(ramREN), 32'h0);
    check("wd_no_dhit", 32'(dhit), 32'h0);
    check("wd_memerr", 32'(memerr), 32'h0);
    ramstate = RsFree;
    step();

    // Reset arriving mid-fetch
    imemREN = 1'b1; imemaddr = 32'h44; ramstate = RsBusy;
    step();
    check("rstmid_ren", 32'(ramREN), 32'h1);
    nRST = 1'b0; ramstate = RsAccess; ramload = 32'hCAFEF00D;
    step();
    checkAllZero("rstmid");
    nRST = 1'b1; imemREN = 1'b0; ramstate = RsFree;
    step();
    check("rstmid_no_ihit", 32'(ihit), 32'h0);

    // Randomized single transactions against the memory model
    expD = 32'h0;
    for (int t = 0; t < 60; t++) begin
      kind  = int'($urandom_range(0, 3));
      busy  = int'($urandom_range(0, 3));
      idx   = int'($urandom_range(0, 15));
      addr  = 32'(idx * 4);
      wdata = $urandom();
      isI   = (kind == 0);
      isWr  = (kind >= 2);
      if (isI) begin
        imemREN = 1'b1; imemaddr = addr; dmemaddr = $urandom();
      end else begin
        dmemREN   = (kind == 1) || (kind == 3);
        dmemWEN   = isWr;
        dmemaddr  = addr;
        dmemstore = wdata;
        imemaddr  = $urandom();
      end
      ramload = isWr ? $urandom() : mem[idx];
      for (int i = 0; i <= busy; i++) begin
        step();
        check("rnd_ren", 32'(ramREN), 32'(!isWr));
        check("rnd_wen", 32'(ramWEN), 32'(isWr));
        check("rnd_addr", ramaddr, addr);
        if (isWr) check("rnd_store", ramstore, wdata);
        check("rnd_nohit", 32'({ihit, dhit}), 32'h0);
        ramstate = (i == busy) ? RsAccess : RsBusy;
      end
      step();
      if (isI) begin
        check("rnd_ihit", 32'(ihit), 32'h1);
        check("rnd_ihit_only", 32'(dhit), 32'h0);
        check("rnd_imemload", imemload, mem[idx]);
      end else begin
        if (!isWr) expD = mem[idx];
        check("rnd_dhit", 32'(dhit), 32'h1);
        check("rnd_dhit_only", 32'(ihit), 32'h0);
        check("rnd_dmemload", dmemload, expD);
      end
      check("rnd_en_off", 32'({ramREN, ramWEN}), 32'h0);
      check("rnd_memerr", 32'(memerr), 32'h0);
      if (isWr) mem[idx] = wdata;
      imemREN = 1'b0; dmemREN = 1'b0; dmemWEN = 1'b0; ramstate = RsFree;
      step();
      check("rnd_hit_pulse", 32'({ihit, dhit}), 32'h0);
      repeat ($urandom_range(0, 2)) step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
